// File: rtl/uart_tx_buf_reader.sv
// UART 8N1 transmitter that streams tx_len bytes out of a synchronous-read TX buffer.
// Optional parity bit when UART_TX_PARITY_EN is defined (even, or odd with PARITY_ODD=1).
module uart_tx_buf_reader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 9,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [9:0]        tx_len,
  input  logic              tx_abort,
  output logic              tx_buf_ren,
  output logic [ADDR_W-1:0] tx_buf_ra,
  input  logic [7:0]        tx_buf_rd,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [10:0] DEPTH = 11'(1 << ADDR_W);

  if (CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx_buf_reader: CLKS_PER_BIT must be >= 2 and PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [10:0]       remaining;
  logic [10:0]       len_clamped;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign len_clamped = ({1'b0, tx_len} > DEPTH) ? DEPTH : {1'b0, tx_len};
  assign bit_end     = (baud_cnt == BAUD_LAST);

  // NOTE: every register below is assigned with <= so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_buf_ren <= 1'b0;
      tx_buf_ra  <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      remaining  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (tx_abort) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_buf_ren <= 1'b0;
      tx_buf_ra  <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      remaining  <= '0;
    end else begin
      tx_buf_ren <= 1'b0;
      tx_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (tx_start) begin
            if (len_clamped == '0) begin
              state   <= S_DONE;
              tx_done <= 1'b1;
            end else begin
              state      <= S_FETCH;
              tx_busy    <= 1'b1;
              tx_buf_ren <= 1'b1;
              tx_buf_ra  <= '0;
              remaining  <= len_clamped;
            end
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          // Read data is only trusted here, one cycle after the ren pulse.
          shreg    <= tx_buf_rd;
`ifdef UART_TX_PARITY_EN
          parity_bit <= (^tx_buf_rd) ^ 1'(PARITY_ODD);
`endif
          tx       <= 1'b0;
          baud_cnt <= '0;
          state    <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            remaining <= remaining - 1'b1;
            if (remaining == 11'd1) begin
              state   <= S_DONE;
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
            end else begin
              // Only advance when another byte follows, so ra tops out at the last byte read.
              tx_buf_ra  <= tx_buf_ra + 1'b1;
              tx_buf_ren <= 1'b1;
              state      <= S_FETCH;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
